finv_arbiter: RTL and testbench

- Shares one reciprocal core (32-bit in, 32-bit out, fixed latency) between N_REQ requesters.
- Performs round-robin arbitration with valid/ready handshakes on both sides and keeps per-requester ordering.
- Computes the result exponent and handles the special cases (zero, denormal, inf, NaN, underflow). The core supplies only the mantissa, because it passes the input exponent through unchanged.
- Sits between the FPU issue logic and the finv core instance.

---
 rtl/finv_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_finv_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/finv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : finv_arbiter
// Purpose  : Round-robin sharing of one reciprocal mantissa core between
//            N_REQ requesters; forms the result exponent and special cases.
// Revision : 1.0 - initial release
// ============================================================================
module finv_arbiter #(
    parameter int N_REQ = 4,
    parameter int LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [32*N_REQ-1:0]  req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic [31:0]          finv_a,
    input  logic [31:0]          finv_b,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [32*N_REQ-1:0]  rsp_data,
    input  logic [N_REQ-1:0]     rsp_ready
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] c_KIND_NORM = 2'd0;
    localparam logic [1:0] c_KIND_ZERO = 2'd1;
    localparam logic [1:0] c_KIND_INF  = 2'd2;
    localparam logic [1:0] c_KIND_NAN  = 2'd3;

    typedef struct packed {
        logic          v;
        logic [IW-1:0] id;
        logic [1:0]    kind;
        logic          s;
        logic [7:0]    e;
        logic          mzero;
    } tag_t;

    logic [IW-1:0]    r_rr_ptr;
    logic [N_REQ-1:0] r_busy;
    logic [N_REQ-1:0] r_rsp_valid;
    logic [31:0]      r_rsp_data [N_REQ];
    logic [31:0]      r_finv_a;
    tag_t             r_tag [LAT+1];

    logic [N_REQ-1:0] w_elig;
    logic [N_REQ-1:0] w_grant;
    logic [N_REQ-1:0] w_retire;
    logic             w_issue;
    logic [IW-1:0]    w_gnt_id;
    int               w_best;
    int               w_dist;
    logic [31:0]      w_op;
    logic [1:0]       w_kind;
    tag_t             w_new_tag;
    tag_t             w_tail;
    logic signed [8:0] w_exp;
    logic [31:0]      w_res;
    logic             w_unused;

    // Only the mantissa field of the core result is meaningful.
    assign w_unused = ^finv_b[31:23];

    assign w_elig = req_valid & ~r_busy;

    // Pick the eligible requester closest above rr_ptr (wrapping around).
    always_comb begin
        w_best   = N_REQ;
        w_dist   = 0;
        w_gnt_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_dist = i - int'(r_rr_ptr);
            if (w_dist < 0) begin
                w_dist = w_dist + N_REQ;
            end
            if (w_elig[i] && (w_dist < w_best)) begin
                w_best   = w_dist;
                w_gnt_id = IW'(i);
            end
        end
        w_issue = (w_best < N_REQ) && rstn;
        w_grant = '0;
        w_op    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_grant[i] = w_issue && (w_gnt_id == IW'(i));
            if (w_grant[i]) begin
                w_op = req_data[32*i +: 32];
            end
        end
    end

    assign req_ready = w_grant;

    always_comb begin
        w_kind = c_KIND_NORM;
        if (w_op[30:23] == 8'h00) begin
            w_kind = c_KIND_ZERO;
        end else if (w_op[30:23] == 8'hFF) begin
            w_kind = (w_op[22:0] == 23'd0) ? c_KIND_INF : c_KIND_NAN;
        end
    end

    always_comb begin
        w_new_tag       = '0;
        w_new_tag.v     = w_issue;
        w_new_tag.id    = w_gnt_id;
        w_new_tag.kind  = w_kind;
        w_new_tag.s     = w_op[31];
        w_new_tag.e     = w_op[30:23];
        w_new_tag.mzero = (w_op[22:0] == 23'd0);
    end

    // Operand register and tag pipeline; the extra stage aligns the tag with
    // the cycle in which the core result is presented.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_finv_a <= '0;
            for (int s = 0; s <= LAT; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            if (w_issue) begin
                r_finv_a <= w_op;
            end
            r_tag[0] <= w_new_tag;
            for (int s = 1; s <= LAT; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    assign finv_a = r_finv_a;
    assign w_tail = r_tag[LAT];

    // Exponent of 1/x: 254-e for an exact power of two, else 253-e because the
    // core mantissa of 2/(1.m) already sits in [1,2).
    always_comb begin
        if (w_tail.mzero) begin
            w_exp = 9'sd254 - $signed({1'b0, w_tail.e});
        end else begin
            w_exp = 9'sd253 - $signed({1'b0, w_tail.e});
        end
        case (w_tail.kind)
            c_KIND_ZERO: w_res = {w_tail.s, 8'hFF, 23'd0};
            c_KIND_INF:  w_res = {w_tail.s, 31'd0};
            c_KIND_NAN:  w_res = 32'h7FC0_0000;
            default: begin
                if (w_exp <= 9'sd0) begin
                    w_res = {w_tail.s, 31'd0};
                end else begin
                    w_res = {w_tail.s, w_exp[7:0],
                             (w_tail.mzero ? 23'd0 : finv_b[22:0])};
                end
            end
        endcase
    end

    always_comb begin
        w_retire = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_retire[i] = w_tail.v && (w_tail.id == IW'(i));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr_ptr <= '0;
        end else if (w_issue) begin
            r_rr_ptr <= (w_gnt_id == IW'(N_REQ-1)) ? '0 : w_gnt_id + 1'b1;
        end
    end

    // busy blocks a requester from issue until its result slot is drained.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy      <= '0;
            r_rsp_valid <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                r_rsp_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_grant[i]) begin
                    r_busy[i] <= 1'b1;
                end else if (r_rsp_valid[i] && rsp_ready[i]) begin
                    r_busy[i] <= 1'b0;
                end
                if (w_retire[i]) begin
                    r_rsp_valid[i] <= 1'b1;
                    r_rsp_data[i]  <= w_res;
                end else if (r_rsp_valid[i] && rsp_ready[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign rsp_valid = r_rsp_valid;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rsp
            assign rsp_data[32*gi +: 32] = r_rsp_data[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_finv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_finv_arbiter
// Purpose  : Self-checking bench for finv_arbiter (LAT=1 and LAT=3 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_finv_arbiter;

    logic         clk = 1'b0;
    logic         rstn;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   rsp_ready;

    logic [3:0]   rdy  [2];
    logic [3:0]   vld  [2];
    logic [127:0] rdat [2];
    logic [31:0]  fa   [2];
    logic [31:0]  fb   [2];

    logic [22:0]  core1    = '0;
    logic [22:0]  core3 [3] = '{default: '0};

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int          st   [2][4];
    int          due  [2][4];
    logic [31:0] mval [2][4];
    int          rr   [2];
    int          lat  [2] = '{1, 3};
    int          m_g;
    logic [3:0]  m_er;
    logic [3:0]  m_ev;

    always #5 clk = ~clk;

    finv_arbiter #(.N_REQ(4), .LAT(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy[0]), .finv_a(fa[0]), .finv_b(fb[0]),
        .rsp_valid(vld[0]), .rsp_data(rdat[0]), .rsp_ready(rsp_ready)
    );

    finv_arbiter #(.N_REQ(4), .LAT(3)) u_dut3 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy[1]), .finv_a(fa[1]), .finv_b(fb[1]),
        .rsp_valid(vld[1]), .rsp_data(rdat[1]), .rsp_ready(rsp_ready)
    );

    // Reciprocal mantissa: frac(2/(1.m)) rounded to nearest; 0 for m==0.
    function automatic logic [22:0] recip(input logic [22:0] m);
        longint d;
        longint q;
        if (m == 23'd0) return 23'd0;
        d = longint'(m) + 64'h80_0000;
        q = ((longint'(1) <<< 47) + d / 2) / d;
        return q[22:0];
    endfunction

    function automatic logic [31:0] exp_result(input logic [31:0] op);
        int          e;
        int          ex;
        logic        s;
        logic [22:0] m;
        s = op[31];
        e = int'(op[30:23]);
        m = op[22:0];
        if (e == 0)   return {s, 8'hFF, 23'h0};
        if (e == 255) return (m == 23'd0) ? {s, 31'h0} : 32'h7FC0_0000;
        ex = (m == 23'd0) ? 254 - e : 253 - e;
        if (ex <= 0)  return {s, 31'h0};
        return {s, 8'(ex), recip(m)};
    endfunction

    // Pipelined core models: result appears LAT edges after finv_a updates.
    always @(posedge clk) begin
        core1    <= recip(fa[0][22:0]);
        core3[0] <= recip(fa[1][22:0]);
        core3[1] <= core3[0];
        core3[2] <= core3[1];
    end
    assign fb[0] = {9'h155, core1};
    assign fb[1] = {9'h0AA, core3[2]};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Per-requester model: 0 idle, 1 computing, 2 result held in slot.
    always @(negedge clk) begin
        cyc++;
        for (int u = 0; u < 2; u++) begin
            if (!rstn) begin
                chk($sformatf("u%0d.rst_req_ready", u), 128'(rdy[u]), 128'd0);
                chk($sformatf("u%0d.rst_rsp_valid", u), 128'(vld[u]), 128'd0);
                for (int i = 0; i < 4; i++) st[u][i] = 0;
                rr[u] = 0;
            end else begin
                for (int i = 0; i < 4; i++)
                    if (st[u][i] == 1 && cyc >= due[u][i]) st[u][i] = 2;
                m_ev = '0;
                for (int i = 0; i < 4; i++) m_ev[i] = (st[u][i] == 2);
                m_g = -1;
                for (int k = 0; k < 4; k++) begin
                    int idx;
                    idx = (rr[u] + k) % 4;
                    if (m_g < 0 && req_valid[idx] && st[u][idx] == 0) m_g = idx;
                end
                m_er = (m_g >= 0) ? 4'(1 << m_g) : 4'd0;
                chk($sformatf("u%0d.req_ready", u), 128'(rdy[u]), 128'(m_er));
                chk($sformatf("u%0d.rsp_valid", u), 128'(vld[u]), 128'(m_ev));
                for (int i = 0; i < 4; i++)
                    if (st[u][i] == 2)
                        chk($sformatf("u%0d.rsp_data[%0d]", u, i),
                            128'(rdat[u][32*i +: 32]), 128'(mval[u][i]));
                for (int i = 0; i < 4; i++)
                    if (st[u][i] == 2 && rsp_ready[i]) st[u][i] = 0;
                if (m_g >= 0) begin
                    st[u][m_g]   = 1;
                    due[u][m_g]  = cyc + lat[u] + 2;
                    mval[u][m_g] = exp_result(req_data[32*m_g +: 32]);
                    rr[u]        = (m_g + 1) % 4;
                end
            end
        end
    end

    initial begin
        rstn      = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = '0;

        chk("model_2p0",   128'(exp_result(32'h4000_0000)), 128'h3F00_0000);
        chk("model_negz",  128'(exp_result(32'h8000_0000)), 128'hFF80_0000);
        chk("model_inf",   128'(exp_result(32'h7F80_0000)), 128'h0000_0000);
        chk("model_nan",   128'(exp_result(32'h7F81_2345)), 128'h7FC0_0000);
        chk("model_flush", 128'(exp_result(32'h7F00_0001)), 128'h0000_0000);
        chk("model_1p5",   128'(exp_result(32'h3FC0_0000)), 128'h3F2A_AAAB);
        chk("model_mant",  128'(recip(23'h40_0000)),        128'h2A_AAAB);

        tick(3);
        rstn = 1'b1;

        // Single op from requester 0, response held until accepted.
        req_valid = 4'b0001;
        req_data[31:0] = 32'h4000_0000;
        #1;
        chk("single.grant", 128'(rdy[0]), 128'h1);
        tick(1);
        tick(1);
        chk("single.early", 128'(vld[0]), 128'h0);
        tick(1);
        chk("single.valid", 128'(vld[0]), 128'h1);
        chk("single.data",  128'(rdat[0][31:0]), 128'h3F00_0000);
        tick(3);
        chk("single.busy",  128'(rdy[0]), 128'h0);
        req_valid = '0;
        rsp_ready = 4'hF;
        tick(6);

        // Special cases, results left in the slots.
        rsp_ready = '0;
        req_valid = 4'hF;
        req_data  = {32'h7F00_0001, 32'h7F81_2345, 32'h7F80_0000, 32'h8000_0000};
        tick(10);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("u%0d.spec_negzero", u), 128'(rdat[u][31:0]),   128'hFF80_0000);
            chk($sformatf("u%0d.spec_inf", u),     128'(rdat[u][63:32]),  128'h0);
            chk($sformatf("u%0d.spec_nan", u),     128'(rdat[u][95:64]),  128'h7FC0_0000);
            chk($sformatf("u%0d.spec_e254", u),    128'(rdat[u][127:96]), 128'h0);
        end
        req_valid = '0;
        rsp_ready = 4'hF;
        tick(1);
        rsp_ready = '0;
        req_valid = 4'hF;
        req_data  = {32'h7E80_0001, 32'h0040_0000, 32'hC040_0000, 32'h3FC0_0000};
        tick(10);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("u%0d.spec_1p5", u),    128'(rdat[u][31:0]),  128'h3F2A_AAAB);
            chk($sformatf("u%0d.spec_denorm", u), 128'(rdat[u][95:64]), 128'h7F80_0000);
        end
        req_valid = '0;
        rsp_ready = 4'hF;
        tick(1);

        // Full-rate round robin with varying operands.
        req_valid = 4'hF;
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < 4; i++) req_data[32*i +: 32] = $urandom;
            tick(1);
        end
        req_valid = '0;
        tick(6);

        // Backpressure on requester 1.
        rsp_ready = 4'b1101;
        req_valid = 4'hF;
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < 4; i++) req_data[32*i +: 32] = 32'h3F80_0000 + 32'(n * 4 + i) * 32'h0001_2345;
            tick(1);
        end
        req_valid = '0;
        rsp_ready = 4'hF;
        tick(6);

        // Asynchronous reset one cycle after an issue.
        req_valid = 4'b0100;
        req_data[95:64] = 32'h4080_0000;
        tick(1);
        #3;
        rstn = 1'b0;
        #1;
        chk("areset.ready1", 128'(rdy[0]), 128'h0);
        chk("areset.ready3", 128'(rdy[1]), 128'h0);
        chk("areset.valid1", 128'(vld[0]), 128'h0);
        tick(2);
        rstn = 1'b1;
        tick(1);
        tick(1);
        chk("areset.fresh_early", 128'(vld[0]), 128'h0);
        tick(1);
        chk("areset.fresh_valid", 128'(vld[0]), 128'h4);
        chk("areset.fresh_data",  128'(rdat[0][95:64]), 128'h3E80_0000);
        req_valid = '0;
        tick(6);

        // Back-to-back issues from three requesters, checked on the LAT=3 copy.
        rsp_ready = '0;
        req_valid = 4'b0111;
        req_data  = {32'h0, 32'h4080_0000, 32'h3FC0_0000, 32'h4000_0000};
        tick(1);
        tick(3);
        chk("lat3.none", 128'(vld[1]), 128'h0);
        tick(1);
        chk("lat3.first",  128'(vld[1]), 128'h1);
        tick(1);
        chk("lat3.second", 128'(vld[1]), 128'h3);
        tick(1);
        chk("lat3.third",  128'(vld[1]), 128'h7);
        chk("lat1.all",    128'(vld[0]), 128'h7);
        chk("lat3.data2",  128'(rdat[1][95:64]), 128'h3E80_0000);
        req_valid = '0;
        rsp_ready = 4'hF;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
